// File: rtl/kmeans_data_loader.sv
// -----------------------------------------------------------------------------
// kmeans_data_loader
//
// Upstream loader for the K-means engine. A valid/ready stream of DATA_W-bit
// words is written first into the centroid array (NUM_CLUSTERS*NUM_DIMS words)
// and then into the point matrix (NUM_POINTS*NUM_DIMS words). After the last
// word is stored, a one-cycle `go` is issued and the arrays are held frozen
// until the engine pulses `done`.
//
// Ports:
//   clk          - single rising-edge clock
//   rst          - synchronous active-high reset (also clears both arrays)
//   start        - begin a load, honoured only in IDLE
//   in_valid     - stream word valid
//   in_ready     - registered stream ready (high in LOAD_CENT / LOAD_MAT)
//   in_data      - stream word
//   in_last      - end-of-frame marker, checked only with the frame check
//   done         - engine completion pulse, honoured only in WAIT_DONE
//   in_centroids - centroid array [0:NUM_CLUSTERS*NUM_DIMS-1]
//   matrix       - point matrix [0:NUM_POINTS*NUM_DIMS-1]
//   go           - one-cycle start pulse to the engine
//   busy         - high in every state except IDLE
//   word_cnt     - words accepted in the current frame
//   err          - sticky framing error
//
// Configuration macro: KMEANS_LOADER_FRAME_CHECK_EN
//   Defined     : in_last is compared against the word position on every
//                 accepted word; a mismatch sets err and aborts to IDLE with
//                 no go (the offending word is still stored).
//   Not defined : in_last is ignored and err stays 0.
// -----------------------------------------------------------------------------
module kmeans_data_loader #(
  parameter int DATA_W       = 13,
  parameter int NUM_DIMS     = 14,
  parameter int NUM_POINTS   = 256,
  parameter int NUM_CLUSTERS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              done,
  output logic [DATA_W-1:0] in_centroids [0:NUM_CLUSTERS*NUM_DIMS-1],
  output logic [DATA_W-1:0] matrix [0:NUM_POINTS*NUM_DIMS-1],
  output logic              go,
  output logic              busy,
  output logic [11:0]       word_cnt,
  output logic              err
);

  localparam int CENT_WORDS  = NUM_CLUSTERS * NUM_DIMS;
  localparam int MAT_WORDS   = NUM_POINTS * NUM_DIMS;
  localparam int TOTAL_WORDS = CENT_WORDS + MAT_WORDS;
  localparam int CENT_IDX_W  = $clog2(CENT_WORDS);
  localparam int MAT_IDX_W   = $clog2(MAT_WORDS);

  localparam logic [11:0] CENT_BASE     = 12'(CENT_WORDS);
  localparam logic [11:0] LAST_CENT_IDX = 12'(CENT_WORDS - 1);
  localparam logic [11:0] LAST_WORD_IDX = 12'(TOTAL_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_CENT = 3'd1,
    LOAD_MAT  = 3'd2,
    FIRE      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t          state_r;
  logic            in_ready_r;
  logic            go_r;
  logic            busy_r;
  logic            err_r;
  logic [11:0]     word_cnt_r;

  logic                  accept_s;
  logic                  frame_err_s;
  logic [11:0]           mat_off_s;
  logic [CENT_IDX_W-1:0] cent_idx_s;
  logic [MAT_IDX_W-1:0]  mat_idx_s;

  // in_ready is only ever high in the two load states, so it qualifies the handshake alone
  assign accept_s   = in_valid && in_ready_r;
  assign mat_off_s  = word_cnt_r - CENT_BASE;
  assign cent_idx_s = word_cnt_r[CENT_IDX_W-1:0];
  assign mat_idx_s  = mat_off_s[MAT_IDX_W-1:0];

`ifdef KMEANS_LOADER_FRAME_CHECK_EN
  // Framing error: in_last must be high exactly on the final word of the frame
  always_comb begin
    frame_err_s = 1'b0;
    if (accept_s) begin
      frame_err_s = (in_last != (word_cnt_r == LAST_WORD_IDX));
    end else begin
      frame_err_s = 1'b0;
    end
  end
`else
  logic unused_in_last_s;
  assign unused_in_last_s = in_last;

  // Frame check disabled: the frame ends purely on the word count
  always_comb begin
    frame_err_s = 1'b0;
  end
`endif

  // Control FSM with registered handshake, pulse, status and counter outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      go_r       <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
      word_cnt_r <= 12'd0;
    end else begin
      go_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= LOAD_CENT;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
            err_r      <= 1'b0;
            word_cnt_r <= 12'd0;
          end
        end
        LOAD_CENT: begin
          if (accept_s) begin
            word_cnt_r <= word_cnt_r + 12'd1;
            if (frame_err_s) begin
              state_r    <= IDLE;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              err_r      <= 1'b1;
            end else if (word_cnt_r == LAST_CENT_IDX) begin
              state_r <= LOAD_MAT;
            end
          end
        end
        LOAD_MAT: begin
          if (accept_s) begin
            word_cnt_r <= word_cnt_r + 12'd1;
            if (frame_err_s) begin
              state_r    <= IDLE;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              err_r      <= 1'b1;
            end else if (word_cnt_r == LAST_WORD_IDX) begin
              // go is registered here so it is high during the FIRE cycle
              state_r    <= FIRE;
              in_ready_r <= 1'b0;
              go_r       <= 1'b1;
            end
          end
        end
        FIRE: begin
          // done is deliberately not looked at in this cycle
          state_r <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // Array storage: cleared by reset, written only on accepted words in a load state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CENT_WORDS; i++) begin
        in_centroids[i] <= '0;
      end
      for (int j = 0; j < MAT_WORDS; j++) begin
        matrix[j] <= '0;
      end
    end else begin
      if (accept_s && (state_r == LOAD_CENT)) begin
        in_centroids[cent_idx_s] <= in_data;
      end
      if (accept_s && (state_r == LOAD_MAT)) begin
        matrix[mat_idx_s] <= in_data;
      end
    end
  end

  assign in_ready = in_ready_r;
  assign go       = go_r;
  assign busy     = busy_r;
  assign err      = err_r;
  assign word_cnt = word_cnt_r;

endmodule

// File: tb/tb_kmeans_data_loader.sv
module tb_kmeans_data_loader;

  localparam int DW = 13;
  localparam int CW = 56;
  localparam int MW = 3584;
  localparam int TW = CW + MW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          done;
  logic [DW-1:0] in_centroids [0:CW-1];
  logic [DW-1:0] matrix [0:MW-1];
  logic          go;
  logic          busy;
  logic [11:0]   word_cnt;
  logic          err;

  // Reference model: expected array contents
  logic [DW-1:0] exp_cent [0:CW-1];
  logic [DW-1:0] exp_mat [0:MW-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kmeans_data_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .done         (done),
    .in_centroids (in_centroids),
    .matrix       (matrix),
    .go           (go),
    .busy         (busy),
    .word_cnt     (word_cnt),
    .err          (err)
  );

  task automatic model_clear();
    for (int i = 0; i < CW; i++) exp_cent[i] = '0;
    for (int i = 0; i < MW; i++) exp_mat[i] = '0;
  endtask

  // Frame word k: centroid area first, then matrix area
  task automatic model_write(input int idx, input logic [DW-1:0] d);
    if (idx < CW) exp_cent[idx] = d;
    else exp_mat[idx - CW] = d;
  endtask

  task automatic check_arrays(input string tag);
    int bad = 0;
    int first = -1;
    logic [DW-1:0] act = '0;
    logic [DW-1:0] req = '0;
    for (int i = 0; i < CW; i++) begin
      if (in_centroids[i] !== exp_cent[i]) begin
        if (first < 0) begin first = i; act = in_centroids[i]; req = exp_cent[i]; end
        bad++;
      end
    end
    for (int i = 0; i < MW; i++) begin
      if (matrix[i] !== exp_mat[i]) begin
        if (first < 0) begin first = CW + i; act = matrix[i]; req = exp_mat[i]; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_arrays: %0d words differ, first word %0d got %0d expected %0d",
               tag, bad, first, act, req);
    end
  endtask

  // Drive n words at negedges; the model assumes every valid word is accepted during a load
  task automatic stream(input int n, input bit stall, input bit rnd, input int last_at);
    int idx = 0;
    int cyc = 0;
    int ready_bad = 0;
    bit v;
    logic [DW-1:0] d;
    while (idx < n && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      v = stall ? bit'($urandom_range(0, 1)) : 1'b1;
      d = rnd ? 13'($urandom) : 13'(idx % 8192);
      in_valid = v;
      in_data  = d;
      in_last  = (idx == last_at);
      if (in_ready !== 1'b1) ready_bad++;
      if (v) begin
        model_write(idx, d);
        idx++;
      end
    end
    checks++;
    if (idx < n || ready_bad != 0) begin
      errors++;
      $display("FAIL stream: words sent %0d of %0d, cycles with in_ready low %0d expected 0",
               idx, n, ready_bad);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || word_cnt !== 12'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL start: in_ready=%b busy=%b word_cnt=%0d err=%b expected 1 1 0 0",
               in_ready, busy, word_cnt, err);
    end
  endtask

  task automatic do_done();
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL done: busy=%b in_ready=%b expected 0 0", busy, in_ready);
    end
  endtask

  // Called right after the final word was driven: checks go timing and that done in FIRE is ignored
  task automatic post_load(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (go !== 1'b1 || word_cnt !== 12'd3640 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_go: go=%b word_cnt=%0d busy=%b in_ready=%b expected 1 3640 1 0",
               tag, go, word_cnt, busy, in_ready);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (go !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_fire_done: go=%b busy=%b expected 0 1", tag, go, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || go !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || word_cnt !== 12'd0) begin
      errors++;
      $display("FAIL reset: in_ready=%b go=%b busy=%b err=%b word_cnt=%0d expected all 0",
               in_ready, go, busy, err, word_cnt);
    end
    model_clear();
    check_arrays("reset");
    rst = 1'b0;
  endtask

  task automatic test_full_load();
    do_start();
    stream(TW, 1'b0, 1'b0, TW - 1);
    post_load("full");
    checks++;
    if (in_centroids[55] !== 13'd55 || matrix[0] !== 13'd56 || matrix[3583] !== 13'd3639) begin
      errors++;
      $display("FAIL full_corners: cent55=%0d mat0=%0d mat3583=%0d expected 55 56 3639",
               in_centroids[55], matrix[0], matrix[3583]);
    end
    check_arrays("full");
  endtask

  task automatic test_wait_done_freeze();
    int bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      start    = 1'b1;
      in_data  = 13'($urandom);
      if (i > 0 && (in_ready !== 1'b0 || busy !== 1'b1 || go !== 1'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL freeze_status: %0d cycles with in_ready/busy/go not 0/1/0 expected 0", bad);
    end
    in_valid = 1'b0;
    check_arrays("freeze");
    // done together with start: start must be ignored
    done = 1'b1;
    @(negedge clk);
    done  = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_with_start: busy=%b in_ready=%b expected 0 0", busy, in_ready);
    end
    do_start();
  endtask

  task automatic test_stall_load();
    stream(TW, 1'b1, 1'b0, TW - 1);
    post_load("stall");
    check_arrays("stall");
    do_done();
  endtask

  task automatic test_reset_midload();
    do_start();
    stream(1000, 1'b1, 1'b1, -1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (word_cnt !== 12'd1000) begin
      errors++;
      $display("FAIL midload_cnt: word_cnt=%0d expected 1000", word_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || word_cnt !== 12'd0 || busy !== 1'b0 || go !== 1'b0) begin
      errors++;
      $display("FAIL midload_rst: in_ready=%b word_cnt=%0d busy=%b go=%b expected 0 0 0 0",
               in_ready, word_cnt, busy, go);
    end
    model_clear();
    check_arrays("midload_rst");
    rst = 1'b0;
  endtask

  task automatic test_frame_check();
    int gos = 0;
    do_start();
`ifdef KMEANS_LOADER_FRAME_CHECK_EN
    stream(101, 1'b0, 1'b1, 100);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL frame_err: err=%b busy=%b in_ready=%b expected 1 0 0", err, busy, in_ready);
    end
    if (go === 1'b1) gos++;
    repeat (4) begin
      @(negedge clk);
      if (go === 1'b1) gos++;
    end
    checks++;
    if (gos != 0 || err !== 1'b1) begin
      errors++;
      $display("FAIL frame_nogo: go pulses %0d err=%b expected 0 1", gos, err);
    end
    check_arrays("frame_err");
    do_start();
    stream(TW, 1'b1, 1'b1, TW - 1);
    post_load("frame_ok");
    check_arrays("frame_ok");
    do_done();
`else
    stream(TW, 1'b0, 1'b1, 100);
    post_load("frame_ignored");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL frame_ignored_err: err=%b expected 0", err);
    end
    check_arrays("frame_ignored");
    do_done();
`endif
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    done     = 1'b0;
    model_clear();
    test_reset();
    test_full_load();
    test_wait_done_freeze();
    test_stall_load();
    test_reset_midload();
    test_frame_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
